booth_substep_reg: RTL and testbench

- One radix-2 Booth multiplication step (add/subtract, then arithmetic shift right), with registered outputs.
- One step consumes one (acc, Q, q0) triple and produces the next triple.
- An iterating 64-bit Booth multiplier chains or loops it 64 times to form the product {acc, Q}.
- Single-cycle latency, valid-qualified.

---
 rtl/booth_pkg.sv | 12 +
 rtl/booth_substep_comb.sv | 60 ++++++
 rtl/booth_substep_reg.sv | 75 +++++++
 tb/tb_booth_substep_reg.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared definitions for the radix-2 Booth step blocks.
//   WIDTH   : default operand width (acc, Q and multiplicand)
//   OP_*    : encoding of the operation reported on the op output
package booth_pkg;

    localparam int WIDTH = 64;

    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_SUB  = 2'b10;

endpackage

// File: rtl/booth_substep_comb.sv
// One combinational radix-2 Booth step: decode {Q[0], q0}, add or subtract
// the multiplicand in WIDTH+1 bits, then arithmetic-shift {sum, Q, q0} right.
// Ports:
//   acc          in  WIDTH  signed accumulator
//   Q            in  WIDTH  multiplier / lower partial product
//   q0           in  1      Booth extra bit (Q[-1])
//   multiplicand in  WIDTH  signed multiplicand M
//   next_acc     out WIDTH  accumulator after the step
//   next_Q       out WIDTH  Q after the step
//   q0_next      out 1      new extra bit
//   op           out 2      operation applied (OP_NONE/OP_ADD/OP_SUB)
module booth_substep_comb #(
    parameter int WIDTH = booth_pkg::WIDTH
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] Q,
    input  logic             q0,
    input  logic [WIDTH-1:0] multiplicand,
    output logic [WIDTH-1:0] next_acc,
    output logic [WIDTH-1:0] next_Q,
    output logic             q0_next,
    output logic [1:0]       op
);
    import booth_pkg::*;

    logic [WIDTH:0] accExt;
    logic [WIDTH:0] mulExt;
    logic [WIDTH:0] sum;

    // One extra sign bit keeps acc +/- M exact, even for the most-negative M.
    assign accExt = {acc[WIDTH-1], acc};
    assign mulExt = {multiplicand[WIDTH-1], multiplicand};

    // Booth recoding of the bit pair {Q[0], q0}.
    always_comb begin
        sum = accExt;
        op  = OP_NONE;
        unique case ({Q[0], q0})
            2'b01: begin
                sum = accExt + mulExt;
                op  = OP_ADD;
            end
            2'b10: begin
                sum = accExt - mulExt;
                op  = OP_SUB;
            end
            default: begin
                sum = accExt;
                op  = OP_NONE;
            end
        endcase
    end

    // Arithmetic shift right by one of {sum, Q, q0}; the extra sum bit
    // supplies the sign so no separate sign replication is needed.
    assign next_acc = sum[WIDTH:1];
    assign next_Q   = {sum[0], Q[WIDTH-1:1]};
    assign q0_next  = Q[0];

endmodule

// File: rtl/booth_substep_reg.sv
// Registered radix-2 Booth step: wraps booth_substep_comb with an output
// register and a one-cycle valid pulse. Results load only when in_valid is
// high; otherwise they hold while out_valid drops.
// Ports:
//   clk, rst_n   clock and synchronous active-low reset
//   in_valid     capture a step this cycle
//   acc, Q, q0, multiplicand   step inputs
//   out_valid    one-cycle pulse per accepted input
//   next_acc, next_Q, q0_next, op   registered step results
module booth_substep_reg #(
    parameter int WIDTH = booth_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] Q,
    input  logic             q0,
    input  logic [WIDTH-1:0] multiplicand,
    output logic             out_valid,
    output logic [WIDTH-1:0] next_acc,
    output logic [WIDTH-1:0] next_Q,
    output logic             q0_next,
    output logic [1:0]       op
);
    import booth_pkg::*;

    logic [WIDTH-1:0] acc_d;
    logic [WIDTH-1:0] Q_d;
    logic             q0_d;
    logic [1:0]       op_d;

    logic             valid_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] Q_q;
    logic             q0_q;
    logic [1:0]       op_q;

    booth_substep_comb #(.WIDTH(WIDTH)) u_step (
        .acc          (acc),
        .Q            (Q),
        .q0           (q0),
        .multiplicand (multiplicand),
        .next_acc     (acc_d),
        .next_Q       (Q_d),
        .q0_next      (q0_d),
        .op           (op_d)
    );

    // Reset wins over in_valid, so a result in flight is discarded.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            acc_q   <= '0;
            Q_q     <= '0;
            q0_q    <= 1'b0;
            op_q    <= OP_NONE;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                acc_q <= acc_d;
                Q_q   <= Q_d;
                q0_q  <= q0_d;
                op_q  <= op_d;
            end
        end
    end

    assign out_valid = valid_q;
    assign next_acc  = acc_q;
    assign next_Q    = Q_q;
    assign q0_next   = q0_q;
    assign op        = op_q;

endmodule

// File: tb/tb_booth_substep_reg.sv
// Bench for booth_substep_reg: the driver pushes reference results into a
// queue, a monitor pops and compares them whenever out_valid is seen, and
// checks that outputs hold while out_valid is low.
module tb_booth_substep_reg;
    localparam int W = 64;

    typedef struct packed {
        logic [W-1:0] acc;
        logic [W-1:0] Q;
        logic         q0;
        logic [1:0]   op;
    } step_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic [W-1:0] acc;
    logic [W-1:0] Q;
    logic         q0;
    logic [W-1:0] multiplicand;
    logic         out_valid;
    logic [W-1:0] next_acc;
    logic [W-1:0] next_Q;
    logic         q0_next;
    logic [1:0]   op;

    int testsRun  = 0;
    int failCount = 0;

    step_t expQ[$];
    step_t lastExp;
    logic  haveLast = 1'b0;

    booth_substep_reg #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .acc          (acc),
        .Q            (Q),
        .q0           (q0),
        .multiplicand (multiplicand),
        .out_valid    (out_valid),
        .next_acc     (next_acc),
        .next_Q       (next_Q),
        .q0_next      (q0_next),
        .op           (op)
    );

    always #5 clk = ~clk;

    // Reference: treat {sum, Q, q0} as one signed number and halve it
    // (floor), with sum being the exact signed acc, acc+M or acc-M.
    function automatic step_t model(input logic [W-1:0] a, input logic [W-1:0] qq,
                                    input logic qbit, input logic [W-1:0] m);
        logic signed [W:0]     s;
        logic signed [2*W+1:0] whole;
        step_t                 r;
        s    = $signed(a);
        r.op = 2'b00;
        if (qq[0] == 1'b0 && qbit == 1'b1) begin
            s    = $signed(a) + $signed(m);
            r.op = 2'b01;
        end else if (qq[0] == 1'b1 && qbit == 1'b0) begin
            s    = $signed(a) - $signed(m);
            r.op = 2'b10;
        end
        whole = $signed({s, qq, qbit});
        whole = whole >>> 1;
        r.acc = whole[2*W:W+1];
        r.Q   = whole[W:1];
        r.q0  = whole[0];
        return r;
    endfunction

    task automatic checkOutput(input string name, input step_t e);
        testsRun++;
        if (next_acc !== e.acc || next_Q !== e.Q || q0_next !== e.q0 || op !== e.op) begin
            failCount++;
            $display("[TB] FAIL %s: got acc=%h Q=%h q0=%b op=%b, want acc=%h Q=%h q0=%b op=%b",
                     name, next_acc, next_Q, q0_next, op, e.acc, e.Q, e.q0, e.op);
        end
    endtask

    // Drive one step (called at posedge+1) and queue its reference result.
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] qq,
                                 input logic qbit, input logic [W-1:0] m);
        in_valid     = 1'b1;
        acc          = a;
        Q            = qq;
        q0           = qbit;
        multiplicand = m;
        expQ.push_back(model(a, qq, qbit, m));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: compare on valid, check hold otherwise.
    initial begin
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                if (expQ.size() == 0) begin
                    testsRun++;
                    failCount++;
                    $display("[TB] FAIL unexpected_valid: got out_valid=1, want 0");
                end else begin
                    lastExp  = expQ.pop_front();
                    haveLast = 1'b1;
                    checkOutput("step", lastExp);
                end
            end else if (haveLast) begin
                checkOutput("hold", lastExp);
            end
        end
    end

    initial begin
        step_t cur;
        logic [W-1:0] ra, rq, rm;
        int waitCycles;

        rst_n = 1'b0; in_valid = 1'b0; acc = '0; Q = '0; q0 = 1'b0; multiplicand = '0;
        lastExp  = '0;
        haveLast = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);

        // Directed vectors, back to back.
        applyStimulus(64'h0, 64'hF0F0F0F0F0F0F0F0, 1'b0, 64'h1);
        applyStimulus(64'h0, 64'h1, 1'b1, 64'h1);
        applyStimulus(64'h0, 64'h1, 1'b0, 64'h1);
        applyStimulus(64'h3, 64'h2, 1'b1, 64'h1);
        applyStimulus(64'h8000000000000000, 64'h2, 1'b1, 64'h8000000000000000);
        idle(3);

        // Subtract of most-negative M: acc - M must not wrap.
        applyStimulus(64'h7FFFFFFFFFFFFFFF, 64'h1, 1'b0, 64'h8000000000000000);
        idle(2);

        // Randomised steps with random gaps; some corner operands mixed in.
        for (int i = 0; i < 200; i++) begin
            ra = {$urandom, $urandom};
            rq = {$urandom, $urandom};
            rm = {$urandom, $urandom};
            if ($urandom_range(0, 7) == 0) rm = 64'h8000000000000000;
            if ($urandom_range(0, 7) == 0) ra = 64'h8000000000000000;
            if ($urandom_range(0, 7) == 0) ra = 64'h7FFFFFFFFFFFFFFF;
            applyStimulus(ra, rq, 1'($urandom_range(0, 1)), rm);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        idle(2);

        // Reset mid-stream: in_valid is high at the reset edge, result dropped.
        applyStimulus(64'h3, 64'h2, 1'b1, 64'h1);
        in_valid = 1'b1; acc = 64'h5; Q = 64'h1; q0 = 1'b0; multiplicand = 64'h9;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        lastExp  = '0;
        rst_n    = 1'b1;
        in_valid = 1'b0;
        idle(2);

        // Full 64-step product -7 * 13, fed back from the reference results.
        cur = '{acc: 64'h0, Q: 64'hFFFFFFFFFFFFFFF9, q0: 1'b0, op: 2'b00};
        for (int i = 0; i < W; i++) begin
            step_t nxt;
            nxt = model(cur.acc, cur.Q, cur.q0, 64'd13);
            applyStimulus(cur.acc, cur.Q, cur.q0, 64'd13);
            cur = nxt;
        end
        @(negedge clk);
        testsRun++;
        if (next_acc !== 64'hFFFFFFFFFFFFFFFF || next_Q !== 64'hFFFFFFFFFFFFFFA5) begin
            failCount++;
            $display("[TB] FAIL product: got {%h,%h}, want {ffffffffffffffff,ffffffffffffffa5}",
                     next_acc, next_Q);
        end
        idle(2);

        // Every queued result must have been presented.
        waitCycles = 0;
        while (expQ.size() != 0 && waitCycles < 20) begin
            @(posedge clk);
            waitCycles++;
        end
        testsRun++;
        if (expQ.size() != 0) begin
            failCount++;
            $display("[TB] FAIL drain: got %0d pending results, want 0", expQ.size());
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
